// File: rtl/alu_pkg.sv
// Shared types and constants for seq_alu: opcodes, FSM states and the
// active-low seven-segment encoding table.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
`ifdef ALU_MUL_EN
        ST_MUL_RUN = 2'b01,
`endif
        ST_DONE    = 2'b10
    } state_t;

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    // Entry i (bits [7i+6:7i]) is the glyph for hex digit i; bit 0 = segment a.
    localparam logic [111:0] HEX_SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        return HEX_SEG_TABLE[7 * int'(nib) +: 7];
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit nibble to active-low seven-segment decoder.
module hex_to_seg
    import alu_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup of the glyph for one hex digit.
    always_comb begin
        seg = hex_seg(nib);
    end

endmodule

// File: rtl/seq_alu.sv
// Clocked N-bit ALU with start/busy/done handshake and seven-segment banks.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 111.
module seq_alu
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [N-1:0]     result,
    output logic             carry,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [7*(N/4)-1:0] seg_a,
    output logic [7*(N/4)-1:0] seg_b,
    output logic [7*(N/4)-1:0] seg_result
);

    localparam int DIG = N / 4;
    localparam int SW  = $clog2(N);
    localparam int CW  = $clog2(N) + 1;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    op_t            op_q, op_d;
    logic [N-1:0]   result_q, result_d;
    logic           carry_q, carry_d;
    logic           ovf_q, ovf_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    logic [N-1:0]   alu_res_s;
    logic           alu_carry_s;
    logic           alu_ovf_s;
    logic [N:0]     sum_s;
    logic [N:0]     diff_s;
    logic [N:0]     shl_s;
    logic [N:0]     shr_s;
    logic [SW-1:0]  amt_s;

`ifdef ALU_MUL_EN
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
`endif

    // Result and flags for the captured operands; MUL reads the finished accumulator.
    always_comb begin
        amt_s       = b_q[SW-1:0];
        sum_s       = {1'b0, a_q} + {1'b0, b_q};
        diff_s      = {1'b0, a_q} - {1'b0, b_q};
        // The extra bit catches the last bit shifted out; it stays 0 for amount 0.
        shl_s       = {1'b0, a_q} << amt_s;
        shr_s       = {a_q, 1'b0} >> amt_s;
        alu_res_s   = '0;
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res_s   = sum_s[N-1:0];
                alu_carry_s = sum_s[N];
                alu_ovf_s   = (a_q[N-1] == b_q[N-1]) && (sum_s[N-1] != a_q[N-1]);
            end
            OP_SUB: begin
                alu_res_s   = diff_s[N-1:0];
                alu_carry_s = diff_s[N];
                alu_ovf_s   = (a_q[N-1] != b_q[N-1]) && (diff_s[N-1] != a_q[N-1]);
            end
            OP_AND: alu_res_s = a_q & b_q;
            OP_OR:  alu_res_s = a_q | b_q;
            OP_XOR: alu_res_s = a_q ^ b_q;
            OP_SHL: begin
                alu_res_s   = shl_s[N-1:0];
                alu_carry_s = shl_s[N];
            end
            OP_SHR: begin
                alu_res_s   = shr_s[N:1];
                alu_carry_s = shr_s[0];
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
                alu_res_s   = acc_q[N-1:0];
                alu_carry_s = |acc_q[2*N-1:N];
                alu_ovf_s   = |acc_q[2*N-1:N];
`else
                alu_res_s   = '0;
                alu_carry_s = 1'b0;
                alu_ovf_s   = 1'b0;
`endif
            end
            default: begin
                alu_res_s   = '0;
                alu_carry_s = 1'b0;
                alu_ovf_s   = 1'b0;
            end
        endcase
    end

    // FSM next-state, operand capture and completion update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
`ifdef ALU_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d  = a;
                    b_d  = b;
                    op_d = op_t'(op);
`ifdef ALU_MUL_EN
                    if (op_t'(op) == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = {{N{1'b0}}, a};
                        mplier_d = b;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = ST_MUL_RUN;
                    end else begin
                        state_d  = ST_DONE;
                    end
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL_RUN: begin
                busy_d   = 1'b1;
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : {2*N{1'b0}});
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL_RUN;
                end
            end
`endif
            ST_DONE: begin
                result_d = alu_res_s;
                carry_d  = alu_carry_s;
                ovf_d    = alu_ovf_s;
                done_d   = 1'b1;
                busy_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef ALU_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign negative = result_q[N-1];
    assign zero     = (result_q == '0);
    assign busy     = busy_q;
    assign done     = done_q;

    for (genvar i = 0; i < DIG; i++) begin : g_digit
        hex_to_seg u_seg_a (.nib(a_q[4*i +: 4]),      .seg(seg_a[7*i +: 7]));
        hex_to_seg u_seg_b (.nib(b_q[4*i +: 4]),      .seg(seg_b[7*i +: 7]));
        hex_to_seg u_seg_r (.nib(result_q[4*i +: 4]), .seg(seg_result[7*i +: 7]));
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (N=8): stimulus pushes expectations, a monitor
// pops and compares them on every done pulse.
module tb_seq_alu;

    localparam int N = 8;
`ifdef ALU_MUL_EN
    localparam int MUL_LAT = N + 2;
`else
    localparam int MUL_LAT = 2;
`endif

    typedef struct {
        string      nm;
        logic [7:0] res;
        logic       c;
        logic       v;
        int         due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic [7:0]  result;
    logic        carry, negative, zero, overflow, busy, done;
    logic [13:0] seg_a, seg_b, seg_result;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    seq_alu #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .result(result), .carry(carry), .negative(negative), .zero(zero),
        .overflow(overflow), .busy(busy), .done(done),
        .seg_a(seg_a), .seg_b(seg_b), .seg_result(seg_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] tseg(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  4'hF: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] r, input logic c,
                         input logic v);
        exp_t e;
        e.nm  = nm;
        e.res = r;
        e.c   = c;
        e.v   = v;
        e.due = cyc + ((o == 3'b111) ? MUL_LAT : 2);
        q.push_back(e);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL timeout: %0d responses outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
                end else begin
                    e = q.pop_front();
                    chk({e.nm, ".result"}, result, e.res);
                    chk({e.nm, ".carry"}, carry, e.c);
                    chk({e.nm, ".overflow"}, overflow, e.v);
                    chk({e.nm, ".negative"}, negative, e.res[7]);
                    chk({e.nm, ".zero"}, zero, e.res == 8'h00);
                    chk({e.nm, ".latency"}, cyc, e.due);
                    chk({e.nm, ".seg_result"}, seg_result, {tseg(e.res[7:4]), tseg(e.res[3:0])});
                    chk({e.nm, ".busy"}, busy, 1'b1);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.result", result, 8'h00);
        chk("rst.carry", carry, 1'b0);
        chk("rst.overflow", overflow, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.seg_a", seg_a, {7'b1000000, 7'b1000000});
        chk("rst.seg_b", seg_b, {7'b1000000, 7'b1000000});
        chk("rst.seg_result", seg_result, {7'b1000000, 7'b1000000});

        issue("add_carry", 3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0); wait_empty();
        issue("add_ovf",   3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1); wait_empty();
        issue("sub_borrow",3'b001, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0); wait_empty();
        issue("sub_zero",  3'b001, 8'h07, 8'h07, 8'h00, 1'b0, 1'b0); wait_empty();
        issue("and",       3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0); wait_empty();
        issue("or",        3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0); wait_empty();
        issue("xor",       3'b100, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0); wait_empty();
        issue("shl1",      3'b101, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0); wait_empty();
        issue("shl7",      3'b101, 8'h03, 8'h0F, 8'h80, 1'b1, 1'b0); wait_empty();
        issue("shr0",      3'b110, 8'h3A, 8'h00, 8'h3A, 1'b0, 1'b0); wait_empty();
        chk("shr0.seg_digits", seg_result, {7'b0110000, 7'b0001000});
        issue("shr3",      3'b110, 8'h85, 8'h0B, 8'h10, 1'b1, 1'b0); wait_empty();

        // Back-to-back at the two-cycle throughput limit.
        issue("b2b_add",   3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        issue("b2b_sub",   3'b001, 8'h03, 8'h04, 8'hFF, 1'b1, 1'b0);
        wait_empty();

`ifdef ALU_MUL_EN
        issue("mul_ovf",   3'b111, 8'h10, 8'h11, 8'h10, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 8'h33; b = 8'h44;
        @(negedge clk);
        start = 1'b0;
        chk("mul.busy_mid", busy, 1'b1);
        chk("mul.seg_a_held", seg_a, {7'b1111001, 7'b1000000});
        chk("mul.seg_b_held", seg_b, {7'b1111001, 7'b1111001});
        wait_empty();
        issue("mul_small", 3'b111, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0); wait_empty();

        // Reset in the middle of a multiply: no completion may follow.
        start = 1'b1; op = 3'b111; a = 8'h10; b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort.busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort.busy", busy, 1'b0);
        chk("abort.done", done, 1'b0);
        chk("abort.result", result, 8'h00);
        chk("abort.seg_a", seg_a, {7'b1000000, 7'b1000000});
        chk("abort.seg_b", seg_b, {7'b1000000, 7'b1000000});
        chk("abort.seg_result", seg_result, {7'b1000000, 7'b1000000});
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
`else
        issue("mul_off",   3'b111, 8'h10, 8'h11, 8'h00, 1'b0, 1'b0); wait_empty();
        rst = 1'b1;
        #1;
        chk("rst2.result", result, 8'h00);
        chk("rst2.busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        issue("post_rst_add", 3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0); wait_empty();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Clocked, parametrised successor to the combinational 4-bit ALU-plus-display block. It provides eight operations on N-bit operands, including an iterative multiply. Operands are captured on a start/busy/done handshake, and result and flags are held in registers. The captured operands and the result drive active-low seven-segment digit banks for direct board display.

## Interface
- N, default 8: operand/result width; legal values 4, 8, 16, 32; DIG = N/4 hex digits per display bank
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- op  in  3  opcode, sampled with start
- a  in  N  first operand, sampled with start
- b  in  N  second operand, sampled with start
- result  out  N  registered result, held until next completion
- carry  out  1  carry/borrow/shift-out/product-overflow flag
- negative  out  1  result[N-1]
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB), upper product nonzero (MUL)
- busy  out  1  high in MUL_RUN and DONE
- done  out  1  one-cycle pulse when result/flags update
- seg_a, seg_b, seg_result  out  7*DIG  digit i in bits [7i+6:7i], segment a = bit 0 … g = bit 6, active-low

## Operation
- Opcodes:
  - 000 ADD
  - 001 SUB (a−b)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL by b[$clog2(N)-1:0]
  - 110 SHR logical, same amount field
  - 111 MUL (unsigned, low N bits kept)
- States: IDLE, MUL_RUN, DONE.
  - IDLE: start=1 captures a, b, op.
    - Non-MUL opcodes: compute, go to DONE.
    - MUL: clear accumulator, set iteration counter = 0, go to MUL_RUN.
  - MUL_RUN: one shift-add step per cycle; after N steps, go to DONE.
  - DONE: done=1, result/flags already valid; go to IDLE next cycle.
- start outside IDLE is ignored. Its operands and opcode are not captured.
- Flags:
  - ADD: carry = carry-out.
  - SUB: carry = borrow (a < b unsigned).
  - ADD/SUB: overflow = signed overflow.
  - Logic ops: carry = 0, overflow = 0.
  - Shifts: carry = last bit shifted out (0 for amount 0); overflow = 0.
  - MUL: carry = overflow = |product[2N-1:N].
- negative and zero are always derived from the registered result.
- seg_a and seg_b show the captured operands. They update on capture, not on raw inputs.
- seg_result follows result.

## Timing
- Reset values:
  - state IDLE
  - result 0, all flags 0
  - busy 0, done 0
  - captured operands 0
  - every digit shows "0" (7'b1000000)
- Non-MUL latency: start sampled at edge k; result, flags and done are valid after edge k+1. Throughput is one op per 2 cycles.
- MUL latency: start at edge k; done is high after edge k+N+1.
- busy rises after edge k (MUL) or k+1 (non-MUL). busy falls with done.
- Reset asserted during MUL_RUN or DONE aborts immediately. All outputs return to reset values. No done pulse is issued.
- result and flags change only on the done cycle or on reset.

## Configuration
- ALU_MUL_EN defined: MUL is iterative as above. Multiplier datapath and counter are present.
- ALU_MUL_EN undefined:
  - No multiplier logic or MUL_RUN state.
  - Opcode 111 completes with non-MUL latency.
  - result = 0, zero = 1, all other flags 0.

## Structure
- alu_pkg holds:
  - op_t enum (8 opcodes)
  - state_t enum
  - SEG_ZERO constant
  - the 16-entry hex-to-segment constant table
- One sub-module, hex_to_seg: combinational 4-bit nibble to 7-bit active-low decoder. It is instantiated DIG times per bank.

## Test plan
All scenarios use N=8, ALU_MUL_EN defined.
- ADD a=0xF0, b=0x20 -> result 0x10, carry 1, overflow 0, done at k+1.
- ADD a=0x7F, b=0x01 -> result 0x80, overflow 1, negative 1, carry 0.
- SUB a=0x05, b=0x07 -> result 0xFE, carry 1, negative 1. Separately, SUB 0x07−0x07 -> result 0x00, zero 1.
- MUL a=0x10, b=0x11 -> result 0x10, carry 1, overflow 1, done at k+9. A start (ADD) at k+3 is ignored, and seg_a still shows "10".
- SHL a=0x81, b=0x01 -> result 0x02, carry 1. SHR a=0x3A, b=0x00 -> result 0x3A, carry 0, seg_result digit1 = 7'b0110000, digit0 = 7'b0001000.
- MUL started, rst pulsed at k+4 -> busy 0, done never pulses, result 0, all seg digits 7'b1000000. A subsequent ADD 1+1 -> 0x02 at k'+1.
